// File: rtl/gf2_poly_divider_131bit_if.sv
// Handshake/data bundle for the 131-bit GF(2) polynomial divider.
// The optional abort input exists only when GF_DIV_ABORT_EN is defined.
interface gf2_poly_divider_131bit_if #(
    parameter int unsigned N = 131
);
    localparam int unsigned YW = 2 * N - 1;

    logic          in_valid;
    logic          in_ready;
    logic [YW-1:0] y;
    logic [N-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [YW-1:0] q;
    logic [N-1:0]  r;
    logic          div_zero;
    logic          busy;
`ifdef GF_DIV_ABORT_EN
    logic          abort;

    modport master (
        output in_valid, y, b, out_ready, abort,
        input  in_ready, out_valid, q, r, div_zero, busy
    );

    modport slave (
        input  in_valid, y, b, out_ready, abort,
        output in_ready, out_valid, q, r, div_zero, busy
    );
`else
    modport master (
        output in_valid, y, b, out_ready,
        input  in_ready, out_valid, q, r, div_zero, busy
    );

    modport slave (
        input  in_valid, y, b, out_ready,
        output in_ready, out_valid, q, r, div_zero, busy
    );
`endif
endinterface

// File: rtl/gf2_poly_divider_131bit.sv
// Bit-serial GF(2) long divider: y = q*b ^ r, one dividend bit per clock.
// Define GF_DIV_ABORT_EN to add an abort input that cancels DIV/DONE.
module gf2_poly_divider_131bit (
    input  logic                        clk,
    input  logic                        rst,
    gf2_poly_divider_131bit_if.slave    io_bus
);
    localparam int unsigned N  = 131;
    localparam int unsigned YW = 2 * N - 1;
    localparam int unsigned DW = $clog2(N);
    localparam int unsigned CW = $clog2(YW);
    localparam logic [CW-1:0] CNT_START = CW'(YW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [YW-1:0] r_y;
    logic [YW-1:0] r_quo;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_rem;
    logic [DW-1:0] r_d;
    logic [CW-1:0] r_cnt;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_div_zero;
    logic          r_busy;

    logic [DW-1:0] w_d;
    logic [N-1:0]  w_t;
    logic          w_qbit;
    logic          w_abort;

    // Degree of the incoming divisor (highest set bit); 0 when b is zero.
    always_comb begin : p_msb
        w_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (io_bus.b[i]) begin
                w_d = DW'(i);
            end
        end
    end

    // Shift the next dividend bit into the partial remainder; its bit d decides the quotient bit.
    assign w_t    = {r_rem[N-2:0], r_y[r_cnt]};
    assign w_qbit = w_t[r_d];

`ifdef GF_DIV_ABORT_EN
    assign w_abort = io_bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin : p_fsm
        if (rst) begin
            r_state     <= S_IDLE;
            r_y         <= '0;
            r_b         <= '0;
            r_d         <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_div_zero  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_abort && (r_state != S_IDLE)) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_div_zero  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.in_valid && r_in_ready) begin
                        r_y        <= io_bus.y;
                        r_b        <= io_bus.b;
                        r_d        <= w_d;
                        r_rem      <= '0;
                        r_quo      <= '0;
                        r_cnt      <= CNT_START;
                        r_in_ready <= 1'b0;
                        // A zero divisor skips DIV and reports immediately.
                        if (io_bus.b == '0) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_div_zero  <= 1'b1;
                        end else begin
                            r_state <= S_DIV;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                S_DIV: begin
                    r_rem <= w_qbit ? (w_t ^ r_b) : w_t;
                    r_quo <= {r_quo[YW-2:0], w_qbit};
                    if (r_cnt == '0) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end

                S_DONE: begin
                    if (io_bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_div_zero  <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_div_zero  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.q         = r_quo;
    assign io_bus.r         = r_rem;
    assign io_bus.div_zero  = r_div_zero;
    assign io_bus.busy      = r_busy;

endmodule

// File: tb/tb_gf2_poly_divider_131bit.sv
// Scoreboard bench for gf2_poly_divider_131bit: directed divisions, zero divisor,
// output back-pressure, async reset mid-division and (GF_DIV_ABORT_EN) abort.
module tb_gf2_poly_divider_131bit;
    localparam int unsigned N  = 131;
    localparam int unsigned YW = 2 * N - 1;

    typedef struct packed {
        logic [YW-1:0] q;
        logic [N-1:0]  r;
        logic          dz;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];

    gf2_poly_divider_131bit_if #(.N(N)) bus ();

    gf2_poly_divider_131bit dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference carry-less multiply, used only to build dividends with a known quotient.
    function automatic logic [YW-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [YW-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (b[i]) acc = acc ^ (YW'(a) << i);
        end
        return acc;
    endfunction

    // Monitor: every accepted result is compared against the oldest expectation.
    initial begin : p_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", YW'(1), YW'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("result_q", bus.q, e.q);
                    chk("result_r", YW'(bus.r), YW'(e.r));
                    chk("result_div_zero", YW'(bus.div_zero), YW'(e.dz));
                end
            end
        end
    end

    task automatic run_div(input logic [YW-1:0] y, input logic [N-1:0] b,
                           input logic [YW-1:0] eq, input logic [N-1:0] er,
                           input logic edz, input int exp_lat, input int hold);
        int lat;
        chk("start_in_ready", YW'(bus.in_ready), YW'(1));
        if (hold > 0) bus.out_ready = 1'b0;
        bus.y        = y;
        bus.b        = b;
        bus.in_valid = 1'b1;
        sb_q.push_back('{q: eq, r: er, dz: edz});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency_edges", YW'(lat), YW'(exp_lat));
        for (int k = 0; k < hold; k++) begin
            chk("hold_q", bus.q, eq);
            chk("hold_r", YW'(bus.r), YW'(er));
            chk("hold_out_valid", YW'(bus.out_valid), YW'(1));
            chk("hold_in_ready", YW'(bus.in_ready), YW'(0));
            bus.in_valid = k[0];
            bus.y        = YW'(16'h1234);
            bus.b        = '0;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_out_valid", YW'(bus.out_valid), YW'(0));
        chk("release_in_ready", YW'(bus.in_ready), YW'(1));
        chk("release_div_zero", YW'(bus.div_zero), YW'(0));
    endtask

    initial begin : p_main
        logic [79:0]  a80;
        logic [N-1:0] a_full;
        logic [N-1:0] b_pat;
        logic [N-1:0] b_full;
        logic [N-1:0] rr;
        n_checks      = 0;
        n_fail        = 0;
        clk           = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.y         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
`ifdef GF_DIV_ABORT_EN
        bus.abort     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", YW'(bus.in_ready), YW'(1));
        chk("reset_out_valid", YW'(bus.out_valid), YW'(0));
        chk("reset_busy", YW'(bus.busy), YW'(0));
        chk("reset_div_zero", YW'(bus.div_zero), YW'(0));
        chk("reset_q", bus.q, YW'(0));
        chk("reset_r", YW'(bus.r), YW'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // (x^2+1)/(x+1) = x+1; (x^2+x+1)/(x+1) = x rem 1; anything / 1 = itself.
        run_div(YW'(5), N'(3), YW'(3), N'(0), 1'b0, 261, 0);
        run_div(YW'(7), N'(3), YW'(2), N'(1), 1'b0, 261, 0);
        run_div(YW'(8'h1F), N'(1), YW'(8'h1F), N'(0), 1'b0, 261, 0);
        run_div(YW'(16'h1234), N'(0), YW'(0), N'(0), 1'b1, 0, 0);

        a80    = {10{8'hAB}};
        b_pat  = {3'b100, {16{8'hCD}}};
        run_div(clmul(N'(a80), b_pat), b_pat, YW'(a80), N'(0), 1'b0, 261, 0);
        a_full = {3'b111, {16{8'hAB}}};
        b_full = {3'b101, {16{8'h5C}}};
        run_div(clmul(a_full, b_full), b_full, YW'(a_full), N'(0), 1'b0, 261, 0);
        rr     = {3'b011, {16{8'h3C}}};
        run_div(clmul(a_full, b_full) ^ YW'(rr), b_full, YW'(a_full), rr, 1'b0, 261, 0);

        run_div(YW'(7), N'(3), YW'(2), N'(1), 1'b0, 261, 20);

        // Async reset roughly 100 cycles into a division; no result expected.
        bus.y        = YW'(5);
        bus.b        = N'(3);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        chk("mid_div_busy", YW'(bus.busy), YW'(1));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_in_ready", YW'(bus.in_ready), YW'(1));
        chk("async_rst_busy", YW'(bus.busy), YW'(0));
        chk("async_rst_out_valid", YW'(bus.out_valid), YW'(0));
        chk("async_rst_q", bus.q, YW'(0));
        chk("async_rst_r", YW'(bus.r), YW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_div(YW'(5), N'(3), YW'(3), N'(0), 1'b0, 261, 0);

`ifdef GF_DIV_ABORT_EN
        begin : abort_case
            logic saw_valid;
            bus.y        = YW'(5);
            bus.b        = N'(3);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            repeat (49) @(posedge clk);
            #1;
            bus.abort = 1'b1;
            @(posedge clk); #1;
            bus.abort = 1'b0;
            chk("abort_in_ready", YW'(bus.in_ready), YW'(1));
            chk("abort_busy", YW'(bus.busy), YW'(0));
            chk("abort_q", bus.q, YW'(0));
            saw_valid = 1'b0;
            repeat (300) begin
                @(posedge clk); #1;
                if (bus.out_valid) saw_valid = 1'b1;
            end
            chk("abort_no_out_valid", YW'(saw_valid), YW'(0));
            run_div(YW'(7), N'(3), YW'(2), N'(1), 1'b0, 261, 0);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", YW'(sb_q.size()), YW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
